// File: rtl/axi_lite_simple_master.sv
// AXI4-Lite master: one single-beat read or write per command, 3 cycles accept-to-rsp_valid with a zero-wait slave.
// Backpressure: cmd_ready only in IDLE (one transaction outstanding); every AXI VALID is held until its handshake.
module axi_lite_simple_master #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      ACLK,
   input  logic                      ARESET,

   input  logic                      cmd_valid,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      cmd_ready,

   output logic                      rsp_valid,
   output logic                      rsp_write,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic [7:0]                err_count,

   output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                M_AXI_AWPROT,
   output logic                      M_AXI_AWVALID,
   input  logic                      M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                      M_AXI_WVALID,
   input  logic                      M_AXI_WREADY,
   input  logic [1:0]                M_AXI_BRESP,
   input  logic                      M_AXI_BVALID,
   output logic                      M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                M_AXI_ARPROT,
   output logic                      M_AXI_ARVALID,
   input  logic                      M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                M_AXI_RRESP,
   input  logic                      M_AXI_RVALID,
   output logic                      M_AXI_RREADY
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WRITE = 3'd1;
   localparam logic [2:0] WRESP = 3'd2;
   localparam logic [2:0] READ  = 3'd3;
   localparam logic [2:0] RDATA = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  aw_done;
   logic                  w_done;

   logic cmd_acc;
   logic aw_hs;
   logic w_hs;
   logic b_hs;
   logic ar_hs;
   logic r_hs;

   assign cmd_acc = cmd_valid & cmd_ready & (state == IDLE);
   assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
   assign w_hs    = M_AXI_WVALID  & M_AXI_WREADY;
   assign b_hs    = M_AXI_BVALID  & M_AXI_BREADY;
   assign ar_hs   = M_AXI_ARVALID & M_AXI_ARREADY;
   assign r_hs    = M_AXI_RVALID  & M_AXI_RREADY;

   // Address/data come straight from the latches, so they cannot move while VALID is up.
   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = wdata_q;
   assign M_AXI_WSTRB  = wstrb_q;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state         <= IDLE;
         cmd_ready     <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_acc) begin
                  cmd_ready <= 1'b0;
                  addr_q    <= cmd_addr;
                  wdata_q   <= cmd_wdata;
                  wstrb_q   <= cmd_wstrb;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  if (cmd_write) begin
                     state         <= WRITE;
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                  end else begin
                     state         <= READ;
                     M_AXI_ARVALID <= 1'b1;
                  end
               end
            end
            WRITE: begin
               // AW and W retire independently; move on once both are done, same-edge included.
               if (aw_hs) begin
                  M_AXI_AWVALID <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  M_AXI_WVALID <= 1'b0;
                  w_done       <= 1'b1;
               end
               if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                  state        <= WRESP;
                  M_AXI_BREADY <= 1'b1;
               end
            end
            WRESP: begin
               if (b_hs) begin
                  M_AXI_BREADY <= 1'b0;
                  state        <= DONE;
               end
            end
            READ: begin
               if (ar_hs) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  state         <= RDATA;
               end
            end
            RDATA: begin
               if (r_hs) begin
                  M_AXI_RREADY <= 1'b0;
                  state        <= DONE;
               end
            end
            DONE: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state         <= IDLE;
               cmd_ready     <= 1'b0;
               M_AXI_AWVALID <= 1'b0;
               M_AXI_WVALID  <= 1'b0;
               M_AXI_BREADY  <= 1'b0;
               M_AXI_ARVALID <= 1'b0;
               M_AXI_RREADY  <= 1'b0;
            end
         endcase
      end
   end

   // Response capture lands on the B/R handshake edge, so rsp_valid coincides with DONE.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
         err_count <= 8'h00;
      end else begin
         rsp_valid <= 1'b0;
         if (cmd_acc) begin
            rsp_write <= cmd_write;
         end
         if ((state == WRESP) && b_hs) begin
            rsp_valid <= 1'b1;
            rsp_resp  <= M_AXI_BRESP;
            rsp_rdata <= '0;
         end
         if ((state == RDATA) && r_hs) begin
            rsp_valid <= 1'b1;
            rsp_resp  <= M_AXI_RRESP;
            rsp_rdata <= M_AXI_RDATA;
         end
         if ((state == DONE) && (rsp_resp != 2'b00) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule
